// File: rtl/toom_split_stream.sv
// Operand splitter: captures one X/Y pair, then streams K zero-extended chunk pairs.
// Build option TOOM_SPLIT_MSB_FIRST_EN issues chunks from K_WAYS-1 down to 0.
module toom_split_stream #(
    parameter int N_BITS = 1024,
    parameter int K_WAYS = 8,
    parameter int GUARD  = 1,
    localparam int CW = N_BITS / K_WAYS,
    localparam int OW = CW + GUARD,
    localparam int IW = $clog2(K_WAYS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N_BITS-1:0] in_x,
    input  logic [N_BITS-1:0] in_y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_a,
    output logic [OW-1:0] out_b,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    output logic          busy
);

    // state  | meaning
    // IDLE   | waiting for an operand pair, in_ready high
    // STREAM | presenting captured chunks, one per accepted beat

    typedef enum logic {IDLE, STREAM} state_t;

    if (N_BITS % K_WAYS != 0) begin : g_bad_width
        $error("toom_split_stream: N_BITS must be a multiple of K_WAYS");
    end
    if (K_WAYS < 2) begin : g_bad_ways
        $error("toom_split_stream: K_WAYS must be at least 2");
    end

`ifdef TOOM_SPLIT_MSB_FIRST_EN
    localparam logic [IW-1:0] FIRST_IDX = IW'(K_WAYS - 1);
    localparam logic [IW-1:0] LAST_IDX  = '0;
`else
    localparam logic [IW-1:0] FIRST_IDX = '0;
    localparam logic [IW-1:0] LAST_IDX  = IW'(K_WAYS - 1);
`endif

    state_t              r_state;
    logic [IW-1:0]       r_idx;
    logic [N_BITS-1:0]   r_x;
    logic [N_BITS-1:0]   r_y;

    state_t              w_state_nxt;
    logic [IW-1:0]       w_idx_nxt;
    logic                w_stream;
    logic                w_last;
    logic                w_accept;
    logic [CW-1:0]       w_chunk_x;
    logic [CW-1:0]       w_chunk_y;

    assign w_stream  = (r_state == STREAM);
    assign w_last    = w_stream && (r_idx == LAST_IDX);
    assign in_ready  = !w_stream || (w_last && out_ready);
    assign w_accept  = in_valid && in_ready;

    assign w_chunk_x = r_x[int'(r_idx) * CW +: CW];
    assign w_chunk_y = r_y[int'(r_idx) * CW +: CW];

    // Outputs come only from captured state; IDLE forces them to zero.
    assign out_valid = w_stream;
    assign busy      = w_stream;
    assign out_last  = w_last;
    assign out_idx   = w_stream ? r_idx : '0;
    assign out_a     = w_stream ? OW'(w_chunk_x) : '0;
    assign out_b     = w_stream ? OW'(w_chunk_y) : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = STREAM;
                    w_idx_nxt   = FIRST_IDX;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (w_last) begin
                        if (w_accept) begin
                            w_idx_nxt = FIRST_IDX;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
`ifdef TOOM_SPLIT_MSB_FIRST_EN
                        w_idx_nxt = r_idx - 1'b1;
`else
                        w_idx_nxt = r_idx + 1'b1;
`endif
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_accept) begin
            r_x <= in_x;
            r_y <= in_y;
        end
    end

endmodule
